// File: rtl/debounce_pkg.sv
// Shared FSM state type and default timing constants for the multi-channel debouncer.
// Defaults assume a 25 MHz clock.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  // 10 ms settle window and 0.5 s long-press threshold at 25 MHz
  localparam int DEFAULT_TERMINAL_COUNT = 250000;
  localparam int DEFAULT_HOLD_COUNT     = 12500000;

  function automatic int cnt_width(input int terminal_count);
    return (terminal_count < 2) ? 1 : $clog2(terminal_count);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, STABLE/COUNT FSM, settle counter and edge pulses.
// Long-press (hold) detection is built only when DEBOUNCE_HOLD_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int TERMINAL_COUNT = DEFAULT_TERMINAL_COUNT
`ifdef DEBOUNCE_HOLD_EN
  , parameter int HOLD_COUNT = DEFAULT_HOLD_COUNT
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_HOLD_EN
  , output logic hold
`endif
);

  localparam int CNT_W = cnt_width(TERMINAL_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMINAL_COUNT - 1);

  logic             sync_q1;
  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_q;
  logic             out_nxt;
  logic             rise_q;
  logic             rise_nxt;
  logic             fall_q;
  logic             fall_nxt;
  logic             differ;
  logic             terminal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= in;
      s       <= sync_q1;
    end
  end

  assign differ   = s ^ out_q;
  assign terminal = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= STABLE;
      cnt    <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STABLE:  if (differ) state_nxt = COUNT;
      COUNT:   if (!differ || terminal) state_nxt = STABLE;
      default: state_nxt = STABLE;
    endcase
  end

  // Any return to STABLE, glitch or commit, leaves the counter at zero
  always_comb begin
    cnt_nxt  = '0;
    out_nxt  = out_q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (state == COUNT && differ) begin
      if (terminal) begin
        out_nxt  = s;
        rise_nxt = s;
        fall_nxt = ~s;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (state == STABLE && differ) begin
      cnt_nxt = CNT_W'(1);
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_COUNT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_COUNT);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_q;

  // Counter parks at HOLD_COUNT after the pulse so each press yields a single hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      hold_q   <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (!out_q) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= HOLD_SAT;
        hold_q   <= 1'b1;
      end else if (hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign hold = hold_q;
`endif

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent debounce channels with rise/fall pulses.
// Define DEBOUNCE_HOLD_EN to add the per-channel long-press hold output.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int TERMINAL_COUNT = DEFAULT_TERMINAL_COUNT,
  parameter int HOLD_COUNT     = DEFAULT_HOLD_COUNT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
`ifdef DEBOUNCE_HOLD_EN
  , output logic [N_CH-1:0] hold
`endif
);

  if (N_CH < 1 || N_CH > 32 || TERMINAL_COUNT < 2 || HOLD_COUNT < 1) begin : g_param_check
    $error("multi_debounce: illegal parameter set");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .TERMINAL_COUNT(TERMINAL_COUNT)
`ifdef DEBOUNCE_HOLD_EN
      , .HOLD_COUNT(HOLD_COUNT)
`endif
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .in     (in[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
`ifdef DEBOUNCE_HOLD_EN
      , .hold (hold[i])
`endif
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever rise/fall/hold is active.
module tb_multi_debounce;

  localparam int N_CH           = 4;
  localparam int TERMINAL_COUNT = 8;
  localparam int HOLD_COUNT     = 20;
  // Inputs change at a negedge; the following edge samples them and counts as
  // the first of the 2+TERMINAL_COUNT edges, so out settles TERMINAL_COUNT+2
  // edges after the drive point.
  localparam int LAT = TERMINAL_COUNT + 2;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
    logic [3:0] out;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] in;
  logic [N_CH-1:0] out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] hold_v;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef DEBOUNCE_HOLD_EN
  logic [N_CH-1:0] hold;
  assign hold_v = hold;
`else
  assign hold_v = '0;
`endif

  multi_debounce #(
    .N_CH(N_CH),
    .TERMINAL_COUNT(TERMINAL_COUNT),
    .HOLD_COUNT(HOLD_COUNT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in     (in),
    .out    (out),
    .rise   (rise),
    .fall   (fall)
`ifdef DEBOUNCE_HOLD_EN
    , .hold (hold)
`endif
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && ((rise | fall | hold_v) != '0)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pulse cycle %0d: rise=%b fall=%b hold=%b out=%b, required no pulse",
                 cyc, rise, fall, hold_v, out);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || rise != mon_e.rise || fall != mon_e.fall ||
            hold_v != mon_e.hold || out != mon_e.out) begin
          miscompares++;
          $display("[TB] FAIL pulse_event got cyc=%0d rise=%b fall=%b hold=%b out=%b, required cyc=%0d rise=%b fall=%b hold=%b out=%b",
                   cyc, rise, fall, hold_v, out, mon_e.cyc, mon_e.rise, mon_e.fall, mon_e.hold, mon_e.out);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [3:0] value);
    in = value;
  endtask

  task automatic push_event(input int delay, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] h, input logic [3:0] o);
    exp_t e;
    e.cyc  = cyc + delay;
    e.rise = r;
    e.fall = f;
    e.hold = h;
    e.out  = o;
    sb.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [3:0] exp_out);
    vectors++;
    if (out !== exp_out) begin
      miscompares++;
      $display("[TB] FAIL %s: out=%b, required %b", name, out, exp_out);
    end
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if ((rise | fall | hold_v) !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL %s: rise=%b fall=%b hold=%b, required all zero", name, rise, fall, hold_v);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in      = '0;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_out", 4'b0000);
      check_quiet("reset_pulses");
    end
    reset_n = 1'b1;
    wait_cycles(5);

    $display("[TB] clean step on channel 0");
    apply_stimulus(4'b0001);
    push_event(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cycles(15);
    check_output("clean_step_high", 4'b0001);
    apply_stimulus(4'b0000);
    push_event(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cycles(20);
    check_output("clean_step_low", 4'b0000);

    $display("[TB] bounce on channel 1");
    for (int k = 0; k < 10; k++) begin
      apply_stimulus((k % 2 == 0) ? 4'b0010 : 4'b0000);
      wait_cycles(3);
    end
    check_output("bounce_quiet", 4'b0000);
    apply_stimulus(4'b0010);
    push_event(LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cycles(15);
    check_output("bounce_settled", 4'b0010);
    apply_stimulus(4'b0000);
    push_event(LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    wait_cycles(20);
    check_output("bounce_low", 4'b0000);

    $display("[TB] glitch on channel 2");
    apply_stimulus(4'b0100);
    wait_cycles(5);
    apply_stimulus(4'b0000);
    wait_cycles(20);
    check_output("glitch_rejected", 4'b0000);

    $display("[TB] simultaneous steps on all channels");
    apply_stimulus(4'b1111);
    push_event(LAT, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
`ifdef DEBOUNCE_HOLD_EN
    push_event(LAT + HOLD_COUNT, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
`endif
    wait_cycles(40);
    check_output("simul_high", 4'b1111);
    apply_stimulus(4'b0000);
    push_event(LAT, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    wait_cycles(20);
    check_output("simul_low", 4'b0000);

    $display("[TB] reset in the middle of a count");
    apply_stimulus(4'b0001);
    wait_cycles(7);
    reset_n = 1'b0;
    #1;
    check_output("reset_mid_immediate", 4'b0000);
    check_quiet("reset_mid_immediate_pulses");
    repeat (2) begin
      @(negedge clk);
      check_output("reset_mid_out", 4'b0000);
      check_quiet("reset_mid_pulses");
    end
    reset_n = 1'b1;
    push_event(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cycles(15);
    check_output("reset_release_high", 4'b0001);
    apply_stimulus(4'b0000);
    push_event(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cycles(20);
    check_output("reset_release_low", 4'b0000);

    $display("[TB] long press on channel 3");
    apply_stimulus(4'b1000);
    push_event(LAT, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
`ifdef DEBOUNCE_HOLD_EN
    push_event(LAT + HOLD_COUNT, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
`endif
    wait_cycles(60);
    check_output("long_press_high", 4'b1000);
    apply_stimulus(4'b0000);
    push_event(LAT, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    wait_cycles(20);
    check_output("long_press_low", 4'b0000);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_events: %0d expected pulses never seen, required 0", sb.size());
      foreach (sb[i])
        $display("[TB] FAIL missing_event cyc=%0d rise=%b fall=%b hold=%b, required but not observed",
                 sb[i].cyc, sb[i].rise, sb[i].fall, sb[i].hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter TERMINAL_COUNT, default 250000: number of consecutive stable cycles required before out changes, minimum 2.
REQ-003 Parameter HOLD_COUNT, default 12500000: long-press threshold in cycles; used only when DEBOUNCE_HOLD_EN is defined.
REQ-004 Port clk, input, 1 bit: single 25 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in, input, N_CH bits: raw asynchronous button or switch levels.
REQ-007 Port out, output, N_CH bits: debounced levels.
REQ-008 Port rise, output, N_CH bits: one-cycle pulse when out[i] goes 0->1.
REQ-009 Port fall, output, N_CH bits: one-cycle pulse when out[i] goes 1->0.
REQ-010 Port hold, output, N_CH bits: one-cycle pulse on a long press; present only with DEBOUNCE_HOLD_EN.

Function
REQ-011 Each in[i] SHALL pass through a 2-flop synchronizer, giving s[i]; no other logic SHALL sample in[i] directly.
REQ-012 Each channel SHALL run a 2-state FSM: STABLE (s==out) and COUNT (s!=out).
REQ-013 In STABLE, cnt SHALL hold at 0; when s!=out, the FSM SHALL enter COUNT with cnt=1.
REQ-014 In COUNT with s==out, the FSM SHALL return to STABLE with cnt=0 (glitch rejected) and out SHALL not change.
REQ-015 In COUNT with s!=out and cnt==TERMINAL_COUNT-1, the next edge SHALL set out<=s, cnt<=0 and state STABLE.
REQ-016 Otherwise in COUNT, cnt SHALL increment by 1.
REQ-017 Latency: a clean input step SHALL appear on out exactly 2+TERMINAL_COUNT cycles after the first clk edge that samples it.
REQ-018 rise[i] and fall[i] SHALL be registered and asserted high for exactly the cycle in which the new out[i] value is first visible.
REQ-019 rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-020 cnt width SHALL be $clog2(TERMINAL_COUNT); cnt SHALL never exceed TERMINAL_COUNT-1 and SHALL never wrap.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each debounce correctly.

Reset
REQ-022 While reset_n=0: sync flops, out, rise, fall, hold, cnt and hold counters SHALL be 0, and every FSM SHALL be in STABLE.
REQ-023 Reset assertion mid-count SHALL abort the count immediately and emit no pulse.
REQ-024 If in[i]=1 at reset release, out[i] SHALL rise 2+TERMINAL_COUNT cycles later with a rise[i] pulse.

Configuration
REQ-025 Macro DEBOUNCE_HOLD_EN SHALL control the long-press feature.
REQ-026 With DEBOUNCE_HOLD_EN defined: a per-channel hold counter SHALL count while out[i]=1.
REQ-027 With DEBOUNCE_HOLD_EN defined: hold[i] SHALL pulse once, for one cycle, when out[i] has been 1 for HOLD_COUNT cycles.
REQ-028 With DEBOUNCE_HOLD_EN defined: the hold counter SHALL saturate after the pulse and clear when out[i]=0.
REQ-029 Without DEBOUNCE_HOLD_EN: the hold port and its counters SHALL be absent, with all other behaviour unchanged.

Structure
REQ-030 Package debounce_pkg SHALL hold the FSM state enum (STABLE, COUNT) and the default TERMINAL_COUNT and HOLD_COUNT constants.
REQ-031 A sub-module debounce_ch SHALL implement one channel (synchronizer, FSM, counter, edge pulses and optional hold logic).
REQ-032 multi_debounce SHALL instantiate N_CH copies of debounce_ch via a generate loop.

Verification (TERMINAL_COUNT=8, HOLD_COUNT=20, N_CH=4)
REQ-033 Clean step: in[0] 0->1 held -> out[0]=1 and rise[0]=1 for exactly 1 cycle, 10 cycles after the sampling edge; other channels stay 0.
REQ-034 Bounce: in[1] toggles every 3 cycles for 30 cycles, then settles at 1 -> no out change during bouncing; out[1] rises 10 cycles after the last toggle.
REQ-035 Glitch: in[2] high for 5 cycles, then low -> out[2], rise[2] and fall[2] stay 0 throughout.
REQ-036 Simultaneous: in=4'b1111 then 4'b0000 after 40 cycles -> all rise bits pulse in the same cycle, then all fall bits pulse together 40 cycles later.
REQ-037 Reset mid-count: assert reset_n=0 at cycle 5 of a count for 2 cycles with in held 1 -> all outputs are 0 during reset; out rises 10 cycles after release.
REQ-038 DEBOUNCE_HOLD_EN: hold in[3]=1 for 60 cycles -> exactly one hold[3] pulse, 20 cycles after out[3] rises; no pulse when the macro is undefined.
